// File: rtl/uart8_rcvr_if.sv
// uart8_rcvr_if
//   Host-side bundle of the UART receiver: the serial line, the host's
//   read-acknowledge pulse, and the received word with its status flags.
//   Signals
//     Serial_in      serial line into the receiver, idle high
//     Read_done      host pulse: word and flags consumed
//     RCV_datareg    last correctly framed word
//     Data_ready     RCV_datareg holds an unread word
//     Error_overrun  a word completed while Data_ready was still set
//     Error_framing  a stop bit was sampled low
//   Modports
//     master  line driver / host: drives Serial_in and Read_done, reads status
//     slave   the receiver: consumes the line and Read_done, drives status
interface uart8_rcvr_if #(
  parameter int WORD_SIZE = 8
);
  logic                 Serial_in;
  logic                 Read_done;
  logic [WORD_SIZE-1:0] RCV_datareg;
  logic                 Data_ready;
  logic                 Error_overrun;
  logic                 Error_framing;

  modport master (
    output Serial_in, Read_done,
    input  RCV_datareg, Data_ready, Error_overrun, Error_framing
  );

  modport slave (
    input  Serial_in, Read_done,
    output RCV_datareg, Data_ready, Error_overrun, Error_framing
  );
endinterface

// File: rtl/uart8_rcvr.sv
// uart8_rcvr
//   Oversampling UART receiver. Frame format: start bit (0), WORD_SIZE data
//   bits LSB first, one stop bit (1). The line is sampled SAMPLES_PER_BIT
//   times per bit; each bit is taken near its centre. A correctly framed word
//   is held in RCV_datareg with Data_ready set until the host pulses
//   Read_done. Overrun and framing errors are sticky until Read_done.
//   Ports
//     Clock   in   sample clock, SAMPLES_PER_BIT x bit rate, rising edge
//     rst_b   in   asynchronous active-low reset
//     bus     slave modport of uart8_rcvr_if (line, Read_done, word, flags)
module uart8_rcvr #(
  parameter int WORD_SIZE       = 8,   // 1..15
  parameter int SAMPLES_PER_BIT = 8    // even, >= 4
) (
  input  logic         Clock,
  input  logic         rst_b,
  uart8_rcvr_if.slave  bus
);

  localparam int HALF  = SAMPLES_PER_BIT / 2;
  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam int BIT_W = $clog2(WORD_SIZE + 1);

  // Compare points for the sample and bit counters.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_SIZE-1:0] shreg;
  logic [WORD_SIZE-1:0] shreg_nxt;

  logic                 sin_m;      // first synchroniser stage
  logic                 sin_s;      // synchronised line
  logic                 sin_p;      // sin_s one clock earlier
  logic                 start_edge;

  logic [WORD_SIZE-1:0] data_q;
  logic                 dr_q;
  logic                 ovr_q;
  logic                 frm_q;

  // Two-flop synchroniser plus one history flop for the falling-edge test.
  // All reset high so that a line already idle at release is not an edge.
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      sin_m <= 1'b1;
      sin_s <= 1'b1;
      sin_p <= 1'b1;
    end else begin
      sin_m <= bus.Serial_in;
      sin_s <= sin_m;
      sin_p <= sin_s;
    end
  end

  // Edge, not level: a line held low (break) cannot retrigger reception.
  assign start_edge = !sin_s && sin_p;

  // Shift right with the new bit entering the MSB so that after WORD_SIZE
  // samples the first-received (LSB) bit sits in bit 0.
  generate
    if (WORD_SIZE == 1) begin : g_shift1
      assign shreg_nxt = sin_s;
    end else begin : g_shiftn
      assign shreg_nxt = {sin_s, shreg[WORD_SIZE-1:1]};
    end
  endgenerate

  // Receive FSM with registered status outputs. The Read_done clear is
  // written first so that any flag set later in the same clock overrides it.
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      dr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      if (bus.Read_done) begin
        dr_q  <= 1'b0;
        ovr_q <= 1'b0;
        frm_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!sin_s) begin
              state   <= RECV;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Counting from mid start bit, a full bit period lands mid data bit.
        RECV: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Returning to IDLE at mid stop bit leaves half a bit of margin
        // for a back-to-back start edge.
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (sin_s) begin
              if (!dr_q || bus.Read_done) begin
                data_q <= shreg;
                dr_q   <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              frm_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.RCV_datareg   = data_q;
  assign bus.Data_ready    = dr_q;
  assign bus.Error_overrun = ovr_q;
  assign bus.Error_framing = frm_q;

endmodule

// File: tb/tb_uart8_rcvr.sv
// tb_uart8_rcvr
//   Directed bench for uart8_rcvr with WORD_SIZE=8, SAMPLES_PER_BIT=8.
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_uart8_rcvr;

  logic Clock = 1'b0;
  logic rst_b = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 Clock = ~Clock;

  uart8_rcvr_if #(.WORD_SIZE(8)) bus ();

  uart8_rcvr #(
    .WORD_SIZE       (8),
    .SAMPLES_PER_BIT (8)
  ) dut (
    .Clock (Clock),
    .rst_b (rst_b),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic dr,
                           input logic ovr, input logic frm);
    check({tag, ".data"}, 16'(bus.RCV_datareg), 16'(d));
    check({tag, ".dr"},   16'(bus.Data_ready), 16'(dr));
    check({tag, ".ovr"},  16'(bus.Error_overrun), 16'(ovr));
    check({tag, ".frm"},  16'(bus.Error_framing), 16'(frm));
  endtask

  // Drives one 80-clock frame. The first line value is sampled by the DUT on
  // the edge of tick 1 ("clock 0"), so clock k is the edge of tick k+1.
  // chk_lat: verify Data_ready is 0 after clock 77 and 1 after clock 78.
  // rd_at: if >0, Read_done is high across the edge of tick rd_at+1.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input bit chk_lat, input int rd_at);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    for (int i = 0; i < 80; i++) begin
      bus.Serial_in = fr[i/8];
      tick();
      if (rd_at > 0 && i + 1 == rd_at)     bus.Read_done = 1'b1;
      if (rd_at > 0 && i + 1 == rd_at + 1) bus.Read_done = 1'b0;
      if (chk_lat && i + 1 == 78) check("lat_clk77", 16'(bus.Data_ready), 16'h0);
      if (chk_lat && i + 1 == 79) check("lat_clk78", 16'(bus.Data_ready), 16'h1);
    end
  endtask

  task automatic read_pulse();
    bus.Read_done = 1'b1;
    tick();
    bus.Read_done = 1'b0;
  endtask

  initial begin
    bus.Serial_in = 1'b1;
    bus.Read_done = 1'b0;

    // Reset state
    ticks(3);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    ticks(10);
    check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 1: single frame, latency to Data_ready
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    bus.Serial_in = 1'b1;
    ticks(4);
    check_all("t1", 8'hA5, 1'b1, 1'b0, 1'b0);
    read_pulse();
    check_all("t1_rd", 8'hA5, 1'b0, 1'b0, 1'b0);

    // 2: back-to-back frames without a read -> overrun, first word kept
    ticks(5);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    check("t2_first", 16'(bus.RCV_datareg), 16'h003C);
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    bus.Serial_in = 1'b1;
    ticks(4);
    check_all("t2", 8'h3C, 1'b1, 1'b1, 1'b0);
    read_pulse();
    check_all("t2_rd", 8'h3C, 1'b0, 1'b0, 1'b0);

    // 3: stop bit 0 -> framing error; then a 40-bit break changes nothing
    ticks(5);
    send_frame(8'h55, 1'b0, 1'b0, 0);
    ticks(2);
    check_all("t3", 8'h3C, 1'b0, 1'b0, 1'b1);
    ticks(320);
    check_all("t3_break", 8'h3C, 1'b0, 1'b0, 1'b1);
    bus.Serial_in = 1'b1;
    ticks(16);
    check_all("t3_idle", 8'h3C, 1'b0, 1'b0, 1'b1);

    // 4: 2-clock low glitch -> false start, nothing changes
    bus.Serial_in = 1'b0;
    ticks(2);
    bus.Serial_in = 1'b1;
    ticks(100);
    check_all("t4", 8'h3C, 1'b0, 1'b0, 1'b1);

    // 5: reset during data bit 4 of 0xFF clears outputs asynchronously
    bus.Serial_in = 1'b0;
    ticks(8);
    bus.Serial_in = 1'b1;
    ticks(36);
    #2 rst_b = 1'b0;
    #1;
    check_all("t5_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst_b = 1'b1;
    ticks(60);
    check_all("t5_after", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    bus.Serial_in = 1'b1;
    ticks(4);
    check_all("t5", 8'h81, 1'b1, 1'b0, 1'b0);

    // 6: Read_done coincides with stop-bit sample while Data_ready=1
    send_frame(8'h0F, 1'b1, 1'b0, 78);
    bus.Serial_in = 1'b1;
    ticks(4);
    check_all("t6", 8'h0F, 1'b1, 1'b0, 1'b0);
    read_pulse();
    check("t6_rd", 16'(bus.Data_ready), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
